// File: rtl/date_counter.sv
// -----------------------------------------------------------------------------
// date_counter
// Day-of-month counter. Advances on day_tick, wraps after the last day of the
// current month and emits a one-clk dateCount carry to the month counter.
// Month length comes back from the month/year stage (month, leap).
// Supports preset via load/data with range checking (load_err), a clamp when
// the month shortens under the current date, and an enable-gated databus.
//
// Configuration macro: LEAP_YEAR_EN
//   defined   : February has 29 days when leap=1, else 28.
//   undefined : leap is ignored, February always has 28 days.
// -----------------------------------------------------------------------------
module date_counter #(
  parameter logic [4:0] RESET_DATE = 5'd1,
  parameter logic [4:0] BUS_IDLE   = 5'd0
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       day_tick,
  input  logic       load,
  input  logic [4:0] data,
  input  logic       enable,
  input  logic [3:0] month,
  input  logic       leap,
  output logic [4:0] date,
  output logic [4:0] databus,
  output logic       dateCount,
  output logic       load_err
);

  logic [4:0] last_day_s;
  logic       load_ok_s;
  logic       at_end_s;
  logic       over_end_s;

`ifndef LEAP_YEAR_EN
  // leap has no effect in this build; tie it off to a named sink
  logic unused_leap_s;
  assign unused_leap_s = leap;
`endif

  // Month length lookup; out-of-range month codes fall back to 31 days
  always_comb begin
    last_day_s = 5'd31;
    case (month)
      4'd2: begin
`ifdef LEAP_YEAR_EN
        if (leap) begin
          last_day_s = 5'd29;
        end else begin
          last_day_s = 5'd28;
        end
`else
        last_day_s = 5'd28;
`endif
      end
      4'd4, 4'd6, 4'd9, 4'd11: last_day_s = 5'd30;
      default:                 last_day_s = 5'd31;
    endcase
  end

  // Range and end-of-month comparisons shared by load, tick and clamp paths
  always_comb begin
    load_ok_s  = 1'b0;
    at_end_s   = 1'b0;
    over_end_s = 1'b0;
    if ((data >= 5'd1) && (data <= last_day_s)) begin
      load_ok_s = 1'b1;
    end else begin
      load_ok_s = 1'b0;
    end
    if (date >= last_day_s) begin
      at_end_s = 1'b1;
    end else begin
      at_end_s = 1'b0;
    end
    if (date > last_day_s) begin
      over_end_s = 1'b1;
    end else begin
      over_end_s = 1'b0;
    end
  end

  // Date state with priority clear_n > load > day_tick > clamp > hold
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      date      <= RESET_DATE;
      dateCount <= 1'b0;
      load_err  <= 1'b0;
    end else if (load) begin
      // a tick arriving with a load is intentionally dropped
      dateCount <= 1'b0;
      if (load_ok_s) begin
        date     <= data;
        load_err <= 1'b0;
      end else begin
        date     <= RESET_DATE;
        load_err <= 1'b1;
      end
    end else if (day_tick) begin
      load_err <= 1'b0;
      if (at_end_s) begin
        date      <= 5'd1;
        dateCount <= 1'b1;
      end else begin
        date      <= date + 5'd1;
        dateCount <= 1'b0;
      end
    end else if (over_end_s) begin
      // month got shorter under us: pull back to its last day, no carry
      date      <= last_day_s;
      dateCount <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      date      <= date;
      dateCount <= 1'b0;
      load_err  <= 1'b0;
    end
  end

  // Readout is unregistered so the bus follows enable in the same cycle
  assign databus = enable ? date : BUS_IDLE;

endmodule

// File: tb/tb_date_counter.sv
// -----------------------------------------------------------------------------
// tb_date_counter
// Directed vectors with hand-computed expectations for date_counter.
// Honors LEAP_YEAR_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_date_counter;

  logic       clk;
  logic       clear_n;
  logic       day_tick;
  logic       load;
  logic [4:0] data;
  logic       enable;
  logic [3:0] month;
  logic       leap;
  logic [4:0] date;
  logic [4:0] databus;
  logic       dateCount;
  logic       load_err;

  int checks;
  int failures;

  date_counter #(
    .RESET_DATE (5'd1),
    .BUS_IDLE   (5'd0)
  ) dut (
    .clk       (clk),
    .clear_n   (clear_n),
    .day_tick  (day_tick),
    .load      (load),
    .data      (data),
    .enable    (enable),
    .month     (month),
    .leap      (leap),
    .date      (date),
    .databus   (databus),
    .dateCount (dateCount),
    .load_err  (load_err)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // advance one posedge and settle 1 ns past it
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [4:0] d, input logic c, input logic e);
    check_eq({tag, ".date"}, {27'd0, date}, {27'd0, d});
    check_eq({tag, ".carry"}, {31'd0, dateCount}, {31'd0, c});
    check_eq({tag, ".err"}, {31'd0, load_err}, {31'd0, e});
  endtask

  task automatic do_load(input logic [4:0] v);
    load = 1'b1;
    data = v;
    step();
    load = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // 1: reset overrides load and tick
    clear_n  = 1'b0;
    load     = 1'b1;
    data     = 5'd15;
    day_tick = 1'b1;
    enable   = 1'b0;
    month    = 4'd1;
    leap     = 1'b0;
    step();
    chk_state("reset", 5'd1, 1'b0, 1'b0);
    check_eq("reset.bus", {27'd0, databus}, 32'd0);
    clear_n  = 1'b1;
    load     = 1'b0;
    day_tick = 1'b0;
    step();
    chk_state("hold", 5'd1, 1'b0, 1'b0);

    // 2: April wrap at 30
    month = 4'd4;
    do_load(5'd29);
    chk_state("apr.load29", 5'd29, 1'b0, 1'b0);
    day_tick = 1'b1;
    step();
    chk_state("apr.tick30", 5'd30, 1'b0, 1'b0);
    step();
    chk_state("apr.wrap", 5'd1, 1'b1, 1'b0);
    day_tick = 1'b0;
    step();
    chk_state("apr.after", 5'd1, 1'b0, 1'b0);

    // 3: February with and without leap
    month = 4'd2;
    leap  = 1'b1;
    do_load(5'd28);
    chk_state("feb.load28", 5'd28, 1'b0, 1'b0);
    day_tick = 1'b1;
    step();
`ifdef LEAP_YEAR_EN
    chk_state("feb.leap29", 5'd29, 1'b0, 1'b0);
    step();
    chk_state("feb.leapwrap", 5'd1, 1'b1, 1'b0);
`else
    chk_state("feb.noen.wrap", 5'd1, 1'b1, 1'b0);
`endif
    day_tick = 1'b0;
    leap     = 1'b0;
    do_load(5'd28);
    day_tick = 1'b1;
    step();
    chk_state("feb.noleap.wrap", 5'd1, 1'b1, 1'b0);
    day_tick = 1'b0;
    leap     = 1'b1;
    do_load(5'd29);
`ifdef LEAP_YEAR_EN
    chk_state("feb.load29", 5'd29, 1'b0, 1'b0);
`else
    chk_state("feb.load29", 5'd1, 1'b0, 1'b1);
`endif
    leap = 1'b0;

    // 4: invalid loads in June
    month = 4'd6;
    do_load(5'd5);
    chk_state("jun.load5", 5'd5, 1'b0, 1'b0);
    do_load(5'd31);
    chk_state("jun.load31", 5'd1, 1'b0, 1'b1);
    step();
    chk_state("jun.errclr", 5'd1, 1'b0, 1'b0);
    do_load(5'd7);
    do_load(5'd0);
    chk_state("jun.load0", 5'd1, 1'b0, 1'b1);
    step();
    chk_state("jun.errclr2", 5'd1, 1'b0, 1'b0);

    // 5: clamp on month change, then load/tick collision
    month = 4'd1;
    do_load(5'd31);
    chk_state("jan.load31", 5'd31, 1'b0, 1'b0);
    month = 4'd2;
    step();
    chk_state("clamp.feb", 5'd28, 1'b0, 1'b0);
    month = 4'd1;
    do_load(5'd31);
    month = 4'd4;
    step();
    chk_state("clamp.apr", 5'd30, 1'b0, 1'b0);
    month    = 4'd2;
    load     = 1'b1;
    data     = 5'd10;
    day_tick = 1'b1;
    step();
    load     = 1'b0;
    day_tick = 1'b0;
    chk_state("collide", 5'd10, 1'b0, 1'b0);

    // out-of-range month behaves as a 31-day month
    month = 4'd0;
    do_load(5'd30);
    day_tick = 1'b1;
    step();
    chk_state("m0.tick31", 5'd31, 1'b0, 1'b0);
    month = 4'd15;
    step();
    chk_state("m15.wrap", 5'd1, 1'b1, 1'b0);
    day_tick = 1'b0;
    month    = 4'd12;
    do_load(5'd31);
    day_tick = 1'b1;
    step();
    chk_state("dec.wrap", 5'd1, 1'b1, 1'b0);
    day_tick = 1'b0;

    // 6: databus follows enable combinationally
    do_load(5'd17);
    enable = 1'b0;
    #1;
    check_eq("bus.off0", {27'd0, databus}, 32'd0);
    enable = 1'b1;
    #1;
    check_eq("bus.on0", {27'd0, databus}, 32'd17);
    enable = 1'b0;
    #1;
    check_eq("bus.off1", {27'd0, databus}, 32'd0);
    enable = 1'b1;
    #1;
    check_eq("bus.on1", {27'd0, databus}, 32'd17);
    step();
    chk_state("bus.date", 5'd17, 1'b0, 1'b0);
    check_eq("bus.on2", {27'd0, databus}, 32'd17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
